// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared bit-level helper for the full adder cells
package full_adder_pkg;

    // carry generate or propagate of one full-adder bit
    function automatic logic fa_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (cin & (a ^ b));
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational 1-bit full-adder cell used in the ripple chain
module full_adder_bit
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder with valid pipeline
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carryout_d, carryout_q;
    logic             out_valid_d, out_valid_q;

    assign c[0] = carry;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // capture the ripple result only on valid operands, otherwise hold
    always_comb begin
        sum_d       = in_valid ? s : sum_q;
        carryout_d  = in_valid ? c[WIDTH] : carryout_q;
        out_valid_d = in_valid;
    end

    // output registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carryout_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carryout_q  <= carryout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign carryout  = carryout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: vector table plus scoreboard checks for 1, 8 and 16 bit adders
`timescale 1ns/1ps
module tb_full_adder;

    typedef struct packed {
        logic [2:0] in;
        logic [1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic        a1, b1, c1, v1, s1, co1, ov1;
    logic [7:0]  a8, b8, s8;
    logic        c8, v8, co8, ov8;
    logic [15:0] a16, b16, s16;
    logic        c16, v16, co16, ov16;

    logic [1:0]  q1[$];
    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    vec_t tbl[8];
    int checks = 0;
    int errors = 0;
    int cnt8 = 0;
    int cnt16 = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .carry(c1), .in_valid(v1),
        .sum(s1), .carryout(co1), .out_valid(ov1)
    );
    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .carry(c8), .in_valid(v8),
        .sum(s8), .carryout(co8), .out_valid(ov8)
    );
    full_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .carry(c16), .in_valid(v16),
        .sum(s16), .carryout(co16), .out_valid(ov16)
    );

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // scoreboard: every pending expectation must meet an out_valid pulse and vice versa
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov1 || q1.size() != 0) begin
                chk("w1_valid", 65'(ov1), 65'(q1.size() != 0));
                if (ov1 && q1.size() != 0) chk("w1_result", 65'({co1, s1}), 65'(q1.pop_front()));
            end
            if (ov8) cnt8++;
            if (ov8 || q8.size() != 0) begin
                chk("w8_valid", 65'(ov8), 65'(q8.size() != 0));
                if (ov8 && q8.size() != 0) chk("w8_result", 65'({co8, s8}), 65'(q8.pop_front()));
            end
            if (ov16) cnt16++;
            if (ov16 || q16.size() != 0) begin
                chk("w16_valid", 65'(ov16), 65'(q16.size() != 0));
                if (ov16 && q16.size() != 0) chk("w16_result", 65'({co16, s16}), 65'(q16.pop_front()));
            end
        end
    end

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] exp);
        @(negedge clk);
        #1;
        a8 = a;
        b8 = b;
        c8 = c;
        v8 = 1'b1;
        q8.push_back(exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{3'd0, 2'b00};
        tbl[1] = '{3'd1, 2'b01};
        tbl[2] = '{3'd2, 2'b01};
        tbl[3] = '{3'd3, 2'b10};
        tbl[4] = '{3'd4, 2'b01};
        tbl[5] = '{3'd5, 2'b10};
        tbl[6] = '{3'd6, 2'b10};
        tbl[7] = '{3'd7, 2'b11};
        rst_n = 1'b0;
        {a1, b1, c1, v1} = '0;
        {a8, b8, c8, v8} = '0;
        {a16, b16, c16, v16} = '0;
        repeat (2) @(negedge clk);
        chk("reset_w1", 65'({ov1, co1, s1}), 65'd0);
        chk("reset_w8", 65'({ov8, co8, s8}), 65'd0);
        chk("reset_w16", 65'({ov16, co16, s16}), 65'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            {a1, b1, c1} = tbl[i].in;
            v1 = 1'b1;
            q1.push_back(tbl[i].exp);
        end
        @(negedge clk);
        #1 v1 = 1'b0;
        drive8(8'hFF, 8'h01, 1'b0, {1'b1, 8'h00});
        drive8(8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF});
        drive8(8'h3C, 8'h42, 1'b1, {1'b0, 8'h7F});
        @(negedge clk);
        #1 v8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom);
            b8 = ~a8;
            c8 = ~c8;
            @(negedge clk);
            #2;
            chk("hold_w8", 65'({ov8, co8, s8}), 65'({1'b0, 1'b0, 8'h7F}));
        end
        chk("w8_pulse_count", 65'(cnt8), 65'd3);
        @(negedge clk);
        #1;
        a8 = 8'h11;
        b8 = 8'h22;
        c8 = 1'b0;
        v8 = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_reset_w8", 65'({ov8, co8, s8}), 65'({1'b1, 1'b0, 8'h33}));
        a8 = 8'h80;
        b8 = 8'h80;
        rst_n = 1'b0;
        #1;
        chk("async_reset_w8", 65'({ov8, co8, s8}), 65'd0);
        @(negedge clk);
        #1;
        v8 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        chk("discard_w8", 65'({ov8, co8, s8}), 65'd0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            v16 = 1'b1;
            q16.push_back(17'(a16) + 17'(b16) + 17'(c16));
        end
        @(negedge clk);
        #1 v16 = 1'b0;
        @(negedge clk);
        #1;
        chk("w16_pulse_count", 65'(cnt16), 65'd1000);
        chk("queues_drained", 65'(q1.size() + q8.size() + q16.size()), 65'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
